// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared widths, constants and occupancy encodings for the IF/ID skid register
package if_id_pkg;

  localparam int                  DEF_INSTR_W   = 32;
  localparam int                  DEF_PC_W      = 32;
  localparam int unsigned         DEF_PC_INC    = 4;
  localparam logic [31:0]         DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/if_id_entry.sv
// rtl/if_id_entry.sv - one {valid, instr, pc_next} slot with load/clear enables and async reset
module if_id_entry #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] CLR_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc_next,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc_next
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_next;

  // Clear wins over load so a flush always empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_instr   <= CLR_INSTR;
      r_pc_next <= '0;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
      r_instr   <= CLR_INSTR;
      r_pc_next <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_instr   <= i_instr;
      r_pc_next <= i_pc_next;
    end
  end

  assign o_valid   = r_valid;
  assign o_instr   = r_instr;
  assign o_pc_next = r_pc_next;

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID register with valid/ready handshake and 2-entry skid; IF_ID_STALL_CNT_EN adds StallCount
module if_id_skid_reg
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 PC_W      = DEF_PC_W,
  parameter int unsigned        PC_INC    = DEF_PC_INC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] InstructionIn,
  input  logic [PC_W-1:0]    PC,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] InstructionOut,
  output logic [PC_W-1:0]    PCID,
  output logic [1:0]         Occupancy
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [15:0]        StallCount
`endif
);

  occ_e               r_occ;
  occ_e               w_occ_nxt;

  logic               w_acc;
  logic               w_con;
  logic               w_head_load;
  logic               w_head_clear;
  logic               w_head_from_skid;
  logic               w_skid_load;
  logic               w_skid_clear;

  logic [PC_W-1:0]    w_in_pc_next;
  logic [INSTR_W-1:0] w_head_din_instr;
  logic [PC_W-1:0]    w_head_din_pc;

  logic               w_head_valid;
  logic [INSTR_W-1:0] w_head_instr;
  logic [PC_W-1:0]    w_head_pc;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;

  assign w_in_pc_next = PC + PC_W'(PC_INC);

  // in_ready comes straight from the skid valid flop: no path from out_ready.
  assign in_ready = ~w_skid_valid;
  assign w_acc    = in_valid & in_ready;
  assign w_con    = w_head_valid & out_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_occ <= OCC_EMPTY;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  always_comb begin
    w_occ_nxt        = r_occ;
    w_head_load      = 1'b0;
    w_head_clear     = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_occ_nxt    = OCC_EMPTY;
      w_head_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_acc) begin
            w_occ_nxt   = OCC_ONE;
            w_head_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_acc && w_con) begin
            w_head_load = 1'b1;
          end else if (w_acc) begin
            w_occ_nxt   = OCC_FULL;
            w_skid_load = 1'b1;
          end else if (w_con) begin
            w_occ_nxt    = OCC_EMPTY;
            w_head_clear = 1'b1;
          end
        end
        OCC_FULL: begin
          if (w_con) begin
            w_occ_nxt        = OCC_ONE;
            w_head_load      = 1'b1;
            w_head_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_occ_nxt    = OCC_EMPTY;
          w_head_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_head_din_instr = w_head_from_skid ? w_skid_instr : InstructionIn;
  assign w_head_din_pc    = w_head_from_skid ? w_skid_pc    : w_in_pc_next;

  if_id_entry #(
    .INSTR_W   (INSTR_W),
    .PC_W      (PC_W),
    .CLR_INSTR (NOP_INSTR)
  ) u_head (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_load    (w_head_load),
    .i_clear   (w_head_clear),
    .i_instr   (w_head_din_instr),
    .i_pc_next (w_head_din_pc),
    .o_valid   (w_head_valid),
    .o_instr   (w_head_instr),
    .o_pc_next (w_head_pc)
  );

  if_id_entry #(
    .INSTR_W   (INSTR_W),
    .PC_W      (PC_W),
    .CLR_INSTR (NOP_INSTR)
  ) u_skid (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_load    (w_skid_load),
    .i_clear   (w_skid_clear),
    .i_instr   (InstructionIn),
    .i_pc_next (w_in_pc_next),
    .o_valid   (w_skid_valid),
    .o_instr   (w_skid_instr),
    .o_pc_next (w_skid_pc)
  );

  assign out_valid      = w_head_valid;
  assign InstructionOut = w_head_valid ? w_head_instr : NOP_INSTR;
  assign PCID           = w_head_valid ? w_head_pc    : '0;
  assign Occupancy      = r_occ;

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of decode stalls; only reset clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_head_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed self-checking bench for if_id_skid_reg
module tb_if_id_skid_reg;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] InstructionIn;
  logic [31:0] PC;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] InstructionOut;
  logic [31:0] PCID;
  logic [1:0]  Occupancy;
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_id_skid_reg dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .InstructionIn  (InstructionIn),
    .PC             (PC),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .InstructionOut (InstructionOut),
    .PCID           (PCID),
    .Occupancy      (Occupancy)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .StallCount     (StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid      = v;
    InstructionIn = ins;
    PC            = pc;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pcid, input logic [1:0] occ, input logic rdy);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".instr"},     64'(InstructionOut), 64'(ins));
    chk({tag, ".pcid"},      64'(PCID), 64'(pcid));
    chk({tag, ".occ"},       64'(Occupancy), 64'(occ));
    chk({tag, ".in_ready"},  64'(in_ready), 64'(rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk_out("rst", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    chk_out("post_rst", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // streaming at full rate
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 32'h0);
    tick();
    chk_out("s0", 1'b1, 32'h11, 32'h4, 2'd1, 1'b1);
    drive(1'b1, 32'h22, 32'h4);
    tick();
    chk_out("s1", 1'b1, 32'h22, 32'h8, 2'd1, 1'b1);
    drive(1'b1, 32'h33, 32'h8);
    tick();
    chk_out("s2", 1'b1, 32'h33, 32'hC, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_out("s_drain", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // backpressure fills the skid
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 32'h100);
    tick();
    chk_out("bp1", 1'b1, 32'hA1, 32'h104, 2'd1, 1'b1);
    drive(1'b1, 32'hA2, 32'h104);
    tick();
    chk_out("bp2", 1'b1, 32'hA1, 32'h104, 2'd2, 1'b0);
    drive(1'b1, 32'hA3, 32'h108);
    tick();
    chk_out("bp3", 1'b1, 32'hA1, 32'h104, 2'd2, 1'b0);
    tick();
    chk_out("bp4", 1'b1, 32'hA1, 32'h104, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("rel1", 1'b1, 32'hA2, 32'h108, 2'd1, 1'b1);
    tick();
    chk_out("rel2", 1'b1, 32'hA3, 32'h10C, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_out("rel3", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // flush while full, with an input offered in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 32'hC1, 32'h300);
    tick();
    drive(1'b1, 32'hC2, 32'h304);
    tick();
    chk("fl_pre.occ", 64'(Occupancy), 64'd2);
    drive(1'b1, 32'hB0, 32'h200);
    flush = 1'b1;
    tick();
    chk_out("fl", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_out("fl_after", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // PC wrap
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    tick();
    chk_out("wrap", 1'b1, 32'hDEAD_BEEF, 32'h0, 2'd1, 1'b1);

    // async reset mid-cycle while full
    drive(1'b1, 32'h55, 32'h10);
    tick();
    chk("ar_pre.occ", 64'(Occupancy), 64'd2);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_out("ar", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
    chk("ar.stall", 64'(StallCount), 64'd0);
`endif
    #2;
    Reset_n   = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h66, 32'h20);
    tick();
    chk_out("ar_first", 1'b1, 32'h66, 32'h24, 2'd1, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_out("ar_drain", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // five stall cycles on a valid head
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 32'h40);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk_out("stall5", 1'b1, 32'h77, 32'h44, 2'd1, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
    chk("stall5.cnt", 64'(StallCount), 64'd5);
`endif
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("stall_fl", 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_fl.cnt", 64'(StallCount), 64'd5);
    Reset_n = 1'b0;
    #1;
    chk("stall_rst.cnt", 64'(StallCount), 64'd0);
    Reset_n = 1'b1;
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
